// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Forwarding select, load-use / PC-write hazard stall and flush
//               control for the 5-stage pipeline, plus a registered match
//               status vector for debug.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_unit #(
    parameter int AW = 6
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          MemToRegE,
    input  logic          BranchTakenE,
    input  logic          PCSrcD,
    input  logic          PCSrcE,
    input  logic          PCSrcM,
    input  logic          PCSrcW,
    input  logic [AW-1:0] RA1D,
    input  logic [AW-1:0] RA2D,
    input  logic [AW-1:0] RA1E,
    input  logic [AW-1:0] RA2E,
    input  logic [AW-1:0] WA3E,
    input  logic [AW-1:0] WA3M,
    input  logic [AW-1:0] WA3W,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic          FlushE,
    output logic [1:0]    FowardAE,
    output logic [1:0]    FowardBE,
    output logic [3:0]    match
);

    localparam logic [1:0] c_FWD_REG = 2'b00;
    localparam logic [1:0] c_FWD_WB  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;

    logic w_m1m;
    logic w_m1w;
    logic w_m2m;
    logic w_m2w;
    logic w_ldrStall;
    logic w_pcWrPendingF;
    logic [3:0] w_matchNext;

    assign w_m1m = (RA1E == WA3M);
    assign w_m1w = (RA1E == WA3W);
    assign w_m2m = (RA2E == WA3M);
    assign w_m2w = (RA2E == WA3W);

    assign w_ldrStall     = MemToRegE & ((RA1D == WA3E) | (RA2D == WA3E));
    assign w_pcWrPendingF = PCSrcD | PCSrcE | PCSrcM;

    assign w_matchNext = {w_m1m & RegWriteM, w_m1w & RegWriteW,
                          w_m2m & RegWriteM, w_m2w & RegWriteW};

    // Reset forces a bubble into Decode/Execute and suppresses all forwarding.
    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        FlushD   = 1'b1;
        FlushE   = 1'b1;
        FowardAE = c_FWD_REG;
        FowardBE = c_FWD_REG;
        if (!reset) begin
            StallF = w_ldrStall | w_pcWrPendingF;
            StallD = w_ldrStall;
            FlushD = w_pcWrPendingF | PCSrcW | BranchTakenE;
            FlushE = w_ldrStall | BranchTakenE;

            // Memory stage holds the younger result, so it wins over Writeback.
            if (w_matchNext[3])
                FowardAE = c_FWD_MEM;
            else if (w_matchNext[2])
                FowardAE = c_FWD_WB;

            if (w_matchNext[1])
                FowardBE = c_FWD_MEM;
            else if (w_matchNext[0])
                FowardBE = c_FWD_WB;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            match <= 4'b0000;
        else
            match <= w_matchNext;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// Self-checking bench for hazard_unit: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_hazard_unit;

    logic       CLK = 1'b0;
    logic       reset;
    logic       RegWriteM, RegWriteW, MemToRegE, BranchTakenE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic [5:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] FowardAE, FowardBE;
    logic [3:0] match;

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] expMatch;

    hazard_unit #(.AW(6)) dut (
        .CLK(CLK), .reset(reset),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .FowardAE(FowardAE), .FowardBE(FowardBE), .match(match)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Forward source for one operand: 2 = Memory, 1 = Writeback, 0 = register file.
    function automatic int fwdOf(input logic [5:0] src);
        if (RegWriteM && src == WA3M) return 2;
        if (RegWriteW && src == WA3W) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] modelMatch();
        return {4{1'b0}} | ((RegWriteM && RA1E == WA3M) ? 4'd8 : 4'd0)
                         | ((RegWriteW && RA1E == WA3W) ? 4'd4 : 4'd0)
                         | ((RegWriteM && RA2E == WA3M) ? 4'd2 : 4'd0)
                         | ((RegWriteW && RA2E == WA3W) ? 4'd1 : 4'd0);
    endfunction

    always @(posedge CLK or posedge reset) begin
        if (reset) expMatch <= 4'd0;
        else       expMatch <= modelMatch();
    end

    // Per-cycle model comparison.
    always @(negedge CLK) begin
        bit loadUse, pcPend;
        int fa, fb;
        loadUse = MemToRegE && (RA1D == WA3E || RA2D == WA3E);
        pcPend  = PCSrcD || PCSrcE || PCSrcM;
        fa = reset ? 0 : fwdOf(RA1E);
        fb = reset ? 0 : fwdOf(RA2E);
        chk("model StallF", {3'b0, StallF}, {3'b0, !reset && (loadUse || pcPend)});
        chk("model StallD", {3'b0, StallD}, {3'b0, !reset && loadUse});
        chk("model FlushD", {3'b0, FlushD}, {3'b0, reset || pcPend || PCSrcW || BranchTakenE});
        chk("model FlushE", {3'b0, FlushE}, {3'b0, reset || loadUse || BranchTakenE});
        chk("model FowardAE", {2'b0, FowardAE}, 4'(fa));
        chk("model FowardBE", {2'b0, FowardBE}, 4'(fb));
        chk("model match", match, expMatch);
    end

    task automatic clearIn();
        {RegWriteM, RegWriteW, MemToRegE, BranchTakenE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic ctl(input string nm, input logic [3:0] exp);
        #1;
        chk(nm, {StallF, StallD, FlushD, FlushE}, exp);
    endtask

    task automatic fwd(input string nm, input logic [1:0] a, input logic [1:0] b);
        #1;
        chk({nm, " A"}, {2'b0, FowardAE}, {2'b0, a});
        chk({nm, " B"}, {2'b0, FowardBE}, {2'b0, b});
    endtask

    initial begin
        clearIn();
        reset = 1'b1;
        RegWriteM = 1; RegWriteW = 1; RA1E = 3; WA3M = 3; RA2E = 7; WA3W = 9;
        fwd("reset fwd", 2'b00, 2'b00);
        ctl("reset ctl", 4'b0011);
        chk("reset match", match, 4'b0000);
        nextCycle();
        chk("reset match held", match, 4'b0000);

        reset = 1'b0;
        fwd("release fwd", 2'b10, 2'b00);
        ctl("release ctl", 4'b0000);
        nextCycle();
        chk("release match", match, 4'b1000);

        RA1E = 1; RA2E = 2; WA3M = 0; WA3W = 2;
        fwd("wb fwd", 2'b00, 2'b01);
        nextCycle();
        chk("wb match", match, 4'b0001);

        RA1E = 3; RA2E = 2; WA3M = 3; WA3W = 2;
        fwd("mem+wb fwd", 2'b10, 2'b01);
        nextCycle();
        chk("mem+wb match", match, 4'b1001);

        // Asynchronous reset clears match without a clock edge.
        #2 reset = 1'b1;
        #1 chk("async reset match", match, 4'b0000);
        ctl("async reset ctl", 4'b0011);
        nextCycle();
        reset = 1'b0;

        RA1E = 1; RA2E = 2; WA3M = 1; WA3W = 1;
        fwd("mem priority fwd", 2'b10, 2'b00);
        nextCycle();
        chk("mem priority match", match, 4'b1100);

        RegWriteW = 0; RA1E = 1; RA2E = 2; WA3W = 2; WA3M = 0;
        fwd("regwrite low fwd", 2'b00, 2'b00);
        nextCycle();
        chk("regwrite low match", match, 4'b0000);

        clearIn();
        fwd("all zero fwd", 2'b00, 2'b00);
        nextCycle();
        chk("all zero match", match, 4'b0000);

        MemToRegE = 1; WA3E = 5; RA2D = 5; RA1D = 1;
        ctl("load-use ctl", 4'b1101);
        nextCycle();
        clearIn();
        PCSrcE = 1;
        ctl("pcsrcE ctl", 4'b1010);
        nextCycle();
        clearIn();
        PCSrcW = 1;
        ctl("pcsrcW ctl", 4'b0010);
        nextCycle();
        clearIn();
        BranchTakenE = 1;
        ctl("branch ctl", 4'b0011);
        nextCycle();
        MemToRegE = 1; WA3E = 4; RA1D = 4; RA2D = 1;
        ctl("load-use+branch ctl", 4'b1111);
        nextCycle();
        clearIn();
        PCSrcD = 1;
        ctl("pcsrcD ctl", 4'b1010);
        nextCycle();

        for (int i = 0; i < 200; i++) begin
            RegWriteM    = 1'($urandom);
            RegWriteW    = 1'($urandom);
            MemToRegE    = 1'($urandom);
            BranchTakenE = ($urandom_range(0, 3) == 0);
            PCSrcD       = ($urandom_range(0, 3) == 0);
            PCSrcE       = ($urandom_range(0, 3) == 0);
            PCSrcM       = ($urandom_range(0, 3) == 0);
            PCSrcW       = ($urandom_range(0, 3) == 0);
            RA1D = 6'($urandom_range(0, 3)); RA2D = 6'($urandom_range(0, 3));
            RA1E = 6'($urandom_range(0, 3)); RA2E = 6'($urandom_range(0, 3));
            WA3E = 6'($urandom_range(0, 3)); WA3M = 6'($urandom_range(0, 3));
            WA3W = 6'($urandom_range(0, 3));
            if (i == 100) reset = 1'b1;
            if (i == 102) reset = 1'b0;
            nextCycle();
        end

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
